// File: rtl/store_queue_pkg.sv
// Shared definitions for the store drain queue: drain FSM states,
// entry layout and word-address slice constants.
package store_queue_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int WORD_HI = 31;
    localparam int WORD_LO = 2;
    localparam int WORD_W  = WORD_HI - WORD_LO + 1;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    // Entries keep only the word address; the byte offset is always zero on drain.
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } sq_entry_t;

endpackage

// File: rtl/store_drain_queue_if.sv
// Memory-side write bus of the store drain queue (req/ack handshake).
interface store_drain_queue_if;
    import store_queue_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   byte_enable;
    logic              ack;

    modport master (output req, output addr, output data, output byte_enable, input ack);
    modport slave  (input req, input addr, input data, input byte_enable, output ack);

endinterface

// File: rtl/sq_forward_mux.sv
// Per-lane youngest-match store-to-load forwarding selection.
// entries[0] is the youngest queued write, entries[DEPTH-1] the oldest slot.
module sq_forward_mux
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              load_request,
    input  logic [WORD_W-1:0] load_word,
    input  sq_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    output logic [BE_W-1:0]   mask,
    output logic [DATA_W-1:0] data
);

    // Walk oldest to youngest so a younger matching lane overwrites an older one.
    always_comb begin
        mask = '0;
        data = '0;
        if (load_request) begin
            for (int lane = 0; lane < BE_W; lane++) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (valid[k] && (entries[k].word == load_word) && entries[k].be[lane]) begin
                        mask[lane]          = 1'b1;
                        data[lane*8 +: 8]   = entries[k].data[lane*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_drain_queue.sv
// Store drain queue: circular write FIFO between the store buffer and data
// memory, draining over a req/ack bus and forwarding queued bytes to loads.
// Optional feature macro: STORE_MERGE_EN (merge a write into the youngest entry).
module store_drain_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_byte_enable,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              load_request,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              fwd_hit,
    output logic [BE_W-1:0]   fwd_byte_mask,
    output logic [DATA_W-1:0] fwd_data,
    store_drain_queue_if.master dmem,
    input  logic              flush_req,
    output logic              flush_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sq_entry_t    entries [DEPTH];
    sq_entry_t    age_entries [DEPTH];
    logic [DEPTH-1:0] age_valid;
    logic [PTR_W-1:0] head_q, tail_q, head_next, tail_last;
    logic [CNT_W-1:0] count_q;
    drain_state_t state_q, state_d;
    sq_entry_t    new_entry, next_head_entry, load_entry;
    logic         enq, pop, merge, load_out, req_d;
    logic         unused_bits;

    // Byte offsets are ignored, and flush is a pure wait: the drain never pauses.
    assign unused_bits = &{1'b0, flush_req, wr_addr[1:0], load_addr[1:0]};

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign flush_done = empty && (state_q == DRAIN_IDLE);
    assign head_next  = head_q + PTR_W'(1);
    assign tail_last  = tail_q - PTR_W'(1);
    assign new_entry  = '{word: wr_addr[WORD_HI:WORD_LO], data: wr_data, be: wr_byte_enable};
    assign enq        = wr_en && !merge && !full;

`ifdef STORE_MERGE_EN
    sq_entry_t merged_entry;

    // Count of at least two keeps the merge target away from the entry being drained.
    always_comb begin
        merged_entry    = entries[tail_last];
        merged_entry.be = entries[tail_last].be | wr_byte_enable;
        for (int lane = 0; lane < BE_W; lane++) begin
            if (wr_byte_enable[lane]) merged_entry.data[lane*8 +: 8] = wr_data[lane*8 +: 8];
        end
    end

    assign merge = wr_en && (count_q >= CNT_W'(2)) &&
                   (entries[tail_last].word == wr_addr[WORD_HI:WORD_LO]);
    assign next_head_entry = (merge && (head_next == tail_last)) ? merged_entry : entries[head_next];
`else
    assign merge = 1'b0;
    assign next_head_entry = entries[head_next];
`endif

    // Entry storage needs no reset; validity comes from head/tail/count.
    always_ff @(posedge clk) begin
        if (enq) entries[tail_q] <= new_entry;
`ifdef STORE_MERGE_EN
        if (merge) entries[tail_last] <= merged_entry;
`endif
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (pop) head_q <= head_next;
            if (enq && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!enq && pop) count_q <= count_q - CNT_W'(1);
            if (wr_en && full && !merge) overflow <= 1'b1;
        end
    end

    // Drain FSM next state: launch from IDLE, pop on ack, chain back-to-back while entries remain.
    always_comb begin
        state_d    = state_q;
        req_d      = dmem.req;
        pop        = 1'b0;
        load_out   = 1'b0;
        load_entry = entries[head_q];
        case (state_q)
            DRAIN_IDLE: begin
                if (!empty) begin
                    load_out = 1'b1;
                    req_d    = 1'b1;
                    state_d  = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                if (dmem.ack) begin
                    pop = 1'b1;
                    if (count_q > CNT_W'(1)) begin
                        load_out   = 1'b1;
                        load_entry = next_head_entry;
                    end else begin
                        req_d   = 1'b0;
                        state_d = DRAIN_IDLE;
                    end
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // Drain FSM state and registered memory-bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= DRAIN_IDLE;
            dmem.req         <= 1'b0;
            dmem.addr        <= '0;
            dmem.data        <= '0;
            dmem.byte_enable <= '0;
        end else begin
            state_q  <= state_d;
            dmem.req <= req_d;
            if (load_out) begin
                dmem.addr        <= {load_entry.word, 2'b00};
                dmem.data        <= load_entry.data;
                dmem.byte_enable <= load_entry.be;
            end
        end
    end

    // Present entries youngest-first with validity for the forwarding mux.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entries[k] = entries[tail_q - PTR_W'(k + 1)];
            age_valid[k]   = (CNT_W'(k) < count_q);
        end
    end

    sq_forward_mux #(.DEPTH(DEPTH)) u_forward_mux (
        .load_request (load_request),
        .load_word    (load_addr[WORD_HI:WORD_LO]),
        .entries      (age_entries),
        .valid        (age_valid),
        .mask         (fwd_byte_mask),
        .data         (fwd_data)
    );

    assign fwd_hit = |fwd_byte_mask;

endmodule

// File: tb/tb_store_drain_queue.sv
// Directed testbench for store_drain_queue (DEPTH=4).
// Inputs change #1 after a rising edge; outputs are checked in that same window.
module tb_store_drain_queue;
    import store_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_byte_enable;
    logic        full, empty, overflow;
    logic        load_request;
    logic [31:0] load_addr;
    logic        fwd_hit;
    logic [3:0]  fwd_byte_mask;
    logic [31:0] fwd_data;
    logic        flush_req, flush_done;
    int          compared = 0;
    int          mismatched = 0;

    store_drain_queue_if dmem_bus ();

    store_drain_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_byte_enable (wr_byte_enable),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .load_request   (load_request),
        .load_addr      (load_addr),
        .fwd_hit        (fwd_hit),
        .fwd_byte_mask  (fwd_byte_mask),
        .fwd_data       (fwd_data),
        .dmem           (dmem_bus),
        .flush_req      (flush_req),
        .flush_done     (flush_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en          = 1'b1;
        wr_addr        = addr;
        wr_data        = data;
        wr_byte_enable = be;
        tick();
        wr_en          = 1'b0;
    endtask

    // Hold ack until the queue empties; an expired budget counts as a failure.
    task automatic drain_all(input string tag);
        int cycles = 0;
        dmem_bus.ack = 1'b1;
        while (!empty && cycles < 20) begin
            tick();
            cycles++;
        end
        dmem_bus.ack = 1'b0;
        check(tag, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_enable = '0;
        load_request = 1'b0; load_addr = '0; flush_req = 1'b0; dmem_bus.ack = 1'b0;
        #1;
        check("rst_req",        {31'd0, dmem_bus.req}, 32'd0);
        check("rst_empty",      {31'd0, empty},        32'd1);
        check("rst_full",       {31'd0, full},         32'd0);
        check("rst_overflow",   {31'd0, overflow},     32'd0);
        check("rst_flush_done", {31'd0, flush_done},   32'd1);
        check("rst_fwd_mask",   {28'd0, fwd_byte_mask}, 32'd0);
        check("rst_dmem_addr",  dmem_bus.addr,          32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single write: visible next cycle, request two cycles later, ack empties the queue.
        write(32'h100, 32'hDEADBEEF, 4'hF);
        check("t1_empty_n1", {31'd0, empty},        32'd0);
        check("t1_req_n1",   {31'd0, dmem_bus.req}, 32'd0);
        tick();
        check("t1_req_n2",  {31'd0, dmem_bus.req},       32'd1);
        check("t1_addr",    dmem_bus.addr,               32'h100);
        check("t1_data",    dmem_bus.data,               32'hDEADBEEF);
        check("t1_be",      {28'd0, dmem_bus.byte_enable}, 32'hF);
        check("t1_flush_busy", {31'd0, flush_done},      32'd0);
        flush_req    = 1'b1;
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        check("t1_req_off",    {31'd0, dmem_bus.req}, 32'd0);
        check("t1_empty",      {31'd0, empty},        32'd1);
        check("t1_flush_done", {31'd0, flush_done},   32'd1);
        flush_req = 1'b0;

        // Fill to DEPTH with ack low, then a dropped fifth write.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_full_before_%0d", i), {31'd0, full}, 32'd0);
            write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        end
        check("t2_full", {31'd0, full}, 32'd1);
        write(32'h200, 32'h12345678, 4'hF);
        check("t2_overflow", {31'd0, overflow}, 32'd1);
        check("t2_full_hold", {31'd0, full},    32'd1);
        dmem_bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_req_%0d", i),  {31'd0, dmem_bus.req}, 32'd1);
            check($sformatf("t2_addr_%0d", i), dmem_bus.addr, 32'h100 + 32'(4 * i));
            check($sformatf("t2_data_%0d", i), dmem_bus.data, 32'hA0 + 32'(i));
            tick();
        end
        dmem_bus.ack = 1'b0;
        check("t2_req_off", {31'd0, dmem_bus.req}, 32'd0);
        check("t2_empty",   {31'd0, empty},        32'd1);
        check("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Forwarding: lanes from two writes combine, a younger write wins its lane.
        write(32'h40, 32'h00000011, 4'h1);
        write(32'h40, 32'h00002200, 4'h2);
        load_request = 1'b1;
        load_addr    = 32'h42;
        #1;
        check("t3_mask", {28'd0, fwd_byte_mask}, 32'h3);
        check("t3_data", fwd_data,               32'h00002211);
        check("t3_hit",  {31'd0, fwd_hit},       32'd1);
        write(32'h40, 32'h00000055, 4'h1);
        check("t3_young_data", fwd_data, 32'h00002255);
        load_addr = 32'h44;
        #1;
        check("t3_miss_hit",  {31'd0, fwd_hit},       32'd0);
        check("t3_miss_data", fwd_data,               32'd0);
        load_addr    = 32'h40;
        load_request = 1'b0;
        #1;
        check("t3_noreq_mask", {28'd0, fwd_byte_mask}, 32'd0);
        drain_all("t3_drain_done");
        tick();

        // Three queued, continuous ack: back-to-back requests then idle.
        write(32'h300, 32'h1, 4'hF);
        write(32'h304, 32'h2, 4'hF);
        write(32'h308, 32'h3, 4'hF);
        dmem_bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_req_%0d", i),  {31'd0, dmem_bus.req}, 32'd1);
            check($sformatf("t4_addr_%0d", i), dmem_bus.addr, 32'h300 + 32'(4 * i));
            tick();
        end
        dmem_bus.ack = 1'b0;
        check("t4_req_off", {31'd0, dmem_bus.req}, 32'd0);
        check("t4_empty",   {31'd0, empty},        32'd1);

`ifdef STORE_MERGE_EN
        // Merge into the youngest of two entries: no new entry, bytes and enables combined.
        write(32'h500, 32'h11223344, 4'hF);
        write(32'h504, 32'h0000CCDD, 4'h3);
        write(32'h504, 32'hEE000000, 4'h8);
        dmem_bus.ack = 1'b1;
        check("m_addr0", dmem_bus.addr, 32'h500);
        tick();
        check("m_addr1", dmem_bus.addr, 32'h504);
        check("m_data1", dmem_bus.data, 32'hEE00CCDD);
        check("m_be1",   {28'd0, dmem_bus.byte_enable}, 32'hB);
        tick();
        dmem_bus.ack = 1'b0;
        check("m_req_off", {31'd0, dmem_bus.req}, 32'd0);
        check("m_empty",   {31'd0, empty},        32'd1);
`endif

        // Reset during an active request drops everything asynchronously.
        write(32'h600, 32'h66, 4'hF);
        tick();
        check("t5_req_before", {31'd0, dmem_bus.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_req",      {31'd0, dmem_bus.req}, 32'd0);
        check("t5_empty",    {31'd0, empty},        32'd1);
        check("t5_overflow", {31'd0, overflow},     32'd0);
        check("t5_addr",     dmem_bus.addr,         32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_stay_idle", {31'd0, dmem_bus.req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
